// File: rtl/stump_alu_mc.sv
`default_nettype none
// stump_alu_mc: multi-cycle STUMP ALU. Single-cycle add/sub/logic ops,
// WIDTH-cycle shift-add unsigned multiply; registered result and {N,Z,V,C}.
module stump_alu_mc #(
   parameter int WIDTH  = 16,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] operand_A,
   input  logic [WIDTH-1:0] operand_B,
   input  logic [2:0]       func,
   input  logic             c_in,
   input  logic             csh,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags_out
);
   localparam int            MSB  = WIDTH - 1;
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MULT = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]   a_q, b_q;
   logic [2:0]         func_q;
   logic               cin_q, csh_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [CW-1:0]      cnt_q;

   logic               is_mul;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_nxt;
   logic [WIDTH-1:0]   b_eff, alu_r;
   logic [WIDTH:0]     sum;
   logic               carry_in, alu_v, alu_c;

   assign is_mul = (MUL_EN != 0) && (func == 3'b110);
   assign busy   = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = is_mul ? MULT : EXEC;
         EXEC:    state_nxt = IDLE;
         MULT:    if (cnt_q == LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One shift-add step: upper half accumulates the multiplicand, the
   // lower half starts as the multiplier and is consumed LSB first.
   always_comb begin
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){prod_q[0]}});
      prod_nxt = {mul_sum, prod_q[WIDTH-1:1]};
   end

   // SUB/SBC reuse the adder with inverted B; func[0] selects c_in as carry.
   always_comb begin
      b_eff    = func_q[1] ? ~b_q : b_q;
      carry_in = func_q[0] ? cin_q : func_q[1];
      sum      = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
      alu_r    = b_q;
      alu_c    = csh_q;
      alu_v    = 1'b0;
      case (func_q)
         3'b000, 3'b001, 3'b010, 3'b011: begin
            alu_r = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = (a_q[MSB] == b_eff[MSB]) && (alu_r[MSB] != a_q[MSB]);
         end
         3'b100:  alu_r = a_q & b_q;
         3'b101:  alu_r = a_q | b_q;
         3'b110:  alu_r = a_q;
         default: alu_r = b_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         func_q    <= '0;
         cin_q     <= 1'b0;
         csh_q     <= 1'b0;
         prod_q    <= '0;
         cnt_q     <= '0;
         done      <= 1'b0;
         result    <= '0;
         flags_out <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q    <= operand_A;
                  b_q    <= operand_B;
                  func_q <= func;
                  cin_q  <= c_in;
                  csh_q  <= csh;
                  prod_q <= {{WIDTH{1'b0}}, operand_B};
                  cnt_q  <= '0;
               end
            end
            EXEC: begin
               done      <= 1'b1;
               result    <= alu_r;
               flags_out <= {alu_r[MSB], (alu_r == '0), alu_v, alu_c};
            end
            MULT: begin
               prod_q <= prod_nxt;
               cnt_q  <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  done      <= 1'b1;
                  result    <= prod_nxt[WIDTH-1:0];
                  flags_out <= {prod_nxt[MSB], ~|prod_nxt[WIDTH-1:0], 1'b0,
                                |prod_nxt[2*WIDTH-1:WIDTH]};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stump_alu_mc.sv
`default_nettype none
// tb_stump_alu_mc: randomized and directed checks of stump_alu_mc against an
// arithmetic reference model with a cycle-count latency model.
module tb_stump_alu_mc;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [15:0]   opa = '0, opb = '0;
   logic [2:0]    func = '0;
   logic          c_in = 1'b0, csh = 1'b0;
   logic          busy, done;
   logic [15:0]   result;
   logic [3:0]    flags;

   logic          start8 = 1'b0;
   logic [7:0]    a8 = '0, b8 = '0;
   logic [2:0]    func8 = '0;
   logic          cin8 = 1'b0, csh8 = 1'b0;
   logic          busy8, done8;
   logic [7:0]    result8;
   logic [3:0]    flags8;

   int errors = 0;
   int checks = 0;
   bit checking = 1'b0;

   always #5 clk = ~clk;

   stump_alu_mc #(.WIDTH(16), .MUL_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .operand_A(opa), .operand_B(opb),
      .func(func), .c_in(c_in), .csh(csh), .busy(busy), .done(done),
      .result(result), .flags_out(flags));

   stump_alu_mc #(.WIDTH(8), .MUL_EN(0)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .operand_A(a8), .operand_B(b8),
      .func(func8), .c_in(cin8), .csh(csh8), .busy(busy8), .done(done8),
      .result(result8), .flags_out(flags8));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: returns {N,Z,V,C, result zero-extended to 32 bits}.
   function automatic logic [35:0] model(input int w, input bit mul_en,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] f, input bit ci, input bit cs);
      longint unsigned mask, aa, bb, s, r;
      bit c, v, n, z, am, bm, rm;
      mask = (64'd1 << w) - 64'd1;
      aa = {32'd0, a} & mask;
      bb = {32'd0, b} & mask;
      c = cs; v = 1'b0; r = 0; s = 0;
      am = ((aa >> (w - 1)) & 64'd1) != 0;
      bm = ((bb >> (w - 1)) & 64'd1) != 0;
      case (f)
         3'b000, 3'b001: s = aa + bb + ((f == 3'b001) ? 64'(ci) : 64'd0);
         3'b010, 3'b011: s = aa + (~bb & mask) + ((f == 3'b010) ? 64'd1 : 64'(ci));
         3'b100: r = aa & bb;
         3'b101: r = aa | bb;
         3'b110: begin
            if (mul_en) begin
               s = aa * bb;
               r = s & mask;
               c = (s >> w) != 0;
            end else r = aa;
         end
         default: r = bb;
      endcase
      if (f[2] == 1'b0) begin
         r  = s & mask;
         c  = ((s >> w) & 64'd1) != 0;
         rm = ((r >> (w - 1)) & 64'd1) != 0;
         v  = (f[1] ? (am != bm) : (am == bm)) && (rm != am);
      end
      n = ((r >> (w - 1)) & 64'd1) != 0;
      z = (r == 0);
      return {n, z, v, c, r[31:0]};
   endfunction

   // Latency/acceptance model for the 16-bit instance.
   int          m_rem = 0;
   bit          m_done = 1'b0;
   logic [15:0] m_res = '0, p_res = '0;
   logic [3:0]  m_flags = '0, p_flags = '0;

   initial begin
      logic [35:0] e;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_rem = 0; m_done = 1'b0; m_res = '0; m_flags = '0;
         end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
               m_rem--;
               if (m_rem == 0) begin
                  m_done = 1'b1; m_res = p_res; m_flags = p_flags;
               end
            end else if (start) begin
               e       = model(W, 1'b1, 32'(opa), 32'(opb), func, c_in, csh);
               p_res   = e[15:0];
               p_flags = e[35:32];
               m_rem   = (func == 3'b110) ? W : 1;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (checking) begin
            check("busy",   64'(busy),   64'(m_rem > 0));
            check("done",   64'(done),   64'(m_done));
            check("result", 64'(result), 64'(m_res));
            check("flags",  64'(flags),  64'(m_flags));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin @(posedge clk); #2; n++; end
   endtask

   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] f, input bit ci, input bit cs,
                         input logic [15:0] er, input logic [3:0] ef, input int lat,
                         input bit inject);
      int n;
      check({name, "_model"}, 64'(model(W, 1'b1, 32'(a), 32'(b), f, ci, cs)),
            64'({ef, 16'h0000, er}));
      wait_idle();
      opa = a; opb = b; func = f; c_in = ci; csh = cs; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      opa = 16'($urandom); opb = 16'($urandom); func = 3'($urandom);
      c_in = 1'($urandom); csh = 1'($urandom);
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk); #2; n++;
         start = inject && (n == 3);
         if (start) func = 3'b000;
      end
      start = 1'b0;
      check({name, "_latency"}, 64'(n), 64'(lat));
      check({name, "_result"}, 64'(result), 64'(er));
      check({name, "_flags"}, 64'(flags), 64'(ef));
   endtask

   task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] f, input bit ci, input bit cs);
      logic [35:0] e;
      e = model(8, 1'b0, 32'(a), 32'(b), f, ci, cs);
      a8 = a; b8 = b; func8 = f; cin8 = ci; csh8 = cs; start8 = 1'b1;
      @(posedge clk); #2;
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      check({name, "_busy"}, 64'(busy8), 64'd1);
      @(posedge clk); #2;
      check({name, "_done"}, 64'(done8), 64'd1);
      check({name, "_result"}, 64'(result8), 64'(e[7:0]));
      check({name, "_flags"}, 64'(flags8), 64'(e[35:32]));
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h8000;
         3: return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_busy",   64'(busy),   64'd0);
      check("rst_done",   64'(done),   64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_flags",  64'(flags),  64'd0);
      check("rst_result8", 64'(result8), 64'd0);
      rst_n = 1'b1;
      checking = 1'b1;
      @(posedge clk); #2;

      run_op("add_ovf",  16'h7FFF, 16'h0001, 3'b000, 1'b0, 1'b0, 16'h8000, 4'b1010, 1,  1'b0);
      run_op("sub_zero", 16'h0005, 16'h0005, 3'b010, 1'b0, 1'b0, 16'h0000, 4'b0101, 1,  1'b0);
      run_op("sbc_00",   16'h0000, 16'h0000, 3'b011, 1'b0, 1'b0, 16'hFFFF, 4'b1000, 1,  1'b0);
      run_op("mul_hi",   16'h0100, 16'h0100, 3'b110, 1'b0, 1'b0, 16'h0000, 4'b0101, 16, 1'b0);
      run_op("mul_3x5",  16'h0003, 16'h0005, 3'b110, 1'b0, 1'b0, 16'h000F, 4'b0000, 16, 1'b0);
      run_op("adc_wrap", 16'hFFFF, 16'h0000, 3'b001, 1'b1, 1'b0, 16'h0000, 4'b0101, 1,  1'b0);
      run_op("and_csh",  16'hF0F0, 16'h0FF0, 3'b100, 1'b0, 1'b1, 16'h00F0, 4'b0001, 1,  1'b0);
      run_op("or",       16'h8000, 16'h0001, 3'b101, 1'b1, 1'b0, 16'h8001, 4'b1000, 1,  1'b0);
      run_op("movb",     16'h1234, 16'h0000, 3'b111, 1'b0, 1'b1, 16'h0000, 4'b0101, 1,  1'b0);
      run_op("sub_ovf",  16'h8000, 16'h0001, 3'b010, 1'b0, 1'b0, 16'h7FFF, 4'b0011, 1,  1'b0);
      run_op("mul_max",  16'hFFFF, 16'hFFFF, 3'b110, 1'b0, 1'b0, 16'h0001, 4'b0001, 16, 1'b0);
      run_op("mul_inj",  16'h0003, 16'h0005, 3'b110, 1'b0, 1'b0, 16'h000F, 4'b0000, 16, 1'b1);

      // Abort a multiply with reset five cycles in.
      wait_idle();
      opa = 16'h0100; opb = 16'h0100; func = 3'b110; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy",   64'(busy),   64'd0);
      check("abort_done",   64'(done),   64'd0);
      check("abort_result", 64'(result), 64'd0);
      check("abort_flags",  64'(flags),  64'd0);
      start = 1'b1; func = 3'b000;
      repeat (2) @(posedge clk);
      #2;
      check("abort_start_ignored", 64'(busy), 64'd0);
      start = 1'b0;
      rst_n = 1'b1;
      run_op("add_after", 16'h0001, 16'h0002, 3'b000, 1'b0, 1'b0, 16'h0003, 4'b0000, 1, 1'b0);

      // Free-running random traffic, including starts while busy.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         start = ($urandom_range(0, 2) == 0);
         opa = pick(); opb = pick();
         func = 3'($urandom); c_in = 1'($urandom); csh = 1'($urandom);
      end
      start = 1'b0;
      wait_idle();
      @(posedge clk); #2;

      // 8-bit instance without multiplier.
      check("w8_pass_model", 64'(model(8, 1'b0, 32'h80, 32'h00, 3'b110, 1'b0, 1'b1)),
            64'({4'b1001, 32'h0000_0080}));
      run8("w8_pass", 8'h80, 8'h00, 3'b110, 1'b0, 1'b1);
      check("w8_pass_lit_result", 64'(result8), 64'h80);
      check("w8_pass_lit_flags",  64'(flags8),  64'b1001);
      for (int i = 0; i < 40; i++)
         run8("w8_rand", 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));

      checking = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
